// File: rtl/instruction_prefetch_unit.sv
// Instruction prefetch unit: fetches bytes from instruction memory into a small FIFO feeding IF/ID.
// Latency: first request 2 edges after reset release; push-to-out_valid 1 cycle; one request in flight at most.
// Backpressure: out_ready low lets the FIFO fill; fetching stops at DEPTH entries and resumes after a pop.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   imem_req, imem_addr             read request toward instruction memory (held stable until imem_ack)
//   imem_ack, imem_rdata            memory accept; read data valid in the same cycle
//   out_valid, out_ready            handshake toward decode; out_instr / out_pc carry the FIFO head
//   redirect_valid, redirect_pc     flush the FIFO and restart fetching at redirect_pc
//   fifo_count                      occupied FIFO entries, 0..DEPTH
// Parameter DEPTH: FIFO entries, 2 or 4.
// Optional macro PREFETCH_JUMP_PREDECODE_EN: pushed opcode 2'b10 redirects sequential fetch to its
// 6-bit target within the current 64-byte page; without it fetch is always pc+1.

module instruction_prefetch_unit #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_rdata,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_instr,
  output logic [7:0] out_pc,
  input  logic       redirect_valid,
  input  logic [7:0] redirect_pc,
  output logic [2:0] fifo_count
);

  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t     state;
  logic       started;   // holds off the first request by one edge after reset release
  logic [7:0] fetch_pc;
  logic [2:0] count;
  logic [7:0] ent_instr [DEPTH];
  logic [7:0] ent_pc    [DEPTH];

  logic       push;
  logic       pop;
  logic [2:0] count_after;
  logic [2:0] wr_idx;
  logic [7:0] pc_next;

  always_comb begin
    pop         = (count != 3'd0) && out_ready;
    push        = (state == S_REQ) && imem_ack && !redirect_valid;
    count_after = count + {2'b00, push} - {2'b00, pop};
    // Head entry shifts out before the new entry lands, so write just past the surviving data.
    wr_idx      = count - {2'b00, pop};
    // imem_addr is the PC of the instruction being pushed (held stable throughout REQ).
    pc_next     = imem_addr + 8'd1;
`ifdef PREFETCH_JUMP_PREDECODE_EN
    if (imem_rdata[7:6] == 2'b10) begin
      pc_next = {imem_addr[7:6], imem_rdata[5:0]};
    end
`endif
  end

  // Fetch FSM; imem_req / imem_addr are registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      started   <= 1'b0;
      fetch_pc  <= 8'h00;
      imem_req  <= 1'b0;
      imem_addr <= 8'h00;
    end else begin
      started <= 1'b1;
      case (state)
        S_IDLE: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_pc;
          end else if (started && (count < DEPTH_C)) begin
            state     <= S_REQ;
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
          end
        end
        S_REQ: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            if (imem_ack) begin
              // Response arrives with the redirect: nothing left to discard later.
              state    <= S_IDLE;
              imem_req <= 1'b0;
            end else begin
              state <= S_DROP;
            end
          end else if (imem_ack) begin
            fetch_pc <= pc_next;
            if (count_after < DEPTH_C) begin
              imem_addr <= pc_next;
            end else begin
              state    <= S_IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        S_DROP: begin
          // The stale request stays on the bus until acked; only fetch_pc tracks new redirects.
          if (redirect_valid) begin
            fetch_pc <= redirect_pc;
          end
          if (imem_ack) begin
            state    <= S_IDLE;
            imem_req <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // Shift-register FIFO: entry 0 is always the head, so outputs come straight from flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 3'd0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_instr[i] <= 8'h00;
        ent_pc[i]    <= 8'h00;
      end
    end else if (redirect_valid) begin
      count <= 3'd0;
    end else begin
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          ent_instr[i] <= ent_instr[i+1];
          ent_pc[i]    <= ent_pc[i+1];
        end
      end
      if (push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wr_idx == 3'(i)) begin
            ent_instr[i] <= imem_rdata;
            ent_pc[i]    <= imem_addr;
          end
        end
      end
      count <= count_after;
    end
  end

  assign out_valid  = (count != 3'd0);
  assign out_instr  = ent_instr[0];
  assign out_pc     = ent_pc[0];
  assign fifo_count = count;

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Bench for instruction_prefetch_unit: directed scenarios plus a long randomized run.
// A transaction-level model predicts which fetched bytes reach decode and in what order;
// a separate monitor pops those predictions whenever decode consumes the FIFO head.

module tb_instruction_prefetch_unit;

  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_rdata;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_instr;
  logic [7:0] out_pc;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic [2:0] fifo_count;

  logic [7:0] mem [256];

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] ins;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic [7:0] mpc;
  bit         drop;
  int         total = 0;
  int         bad   = 0;

  instruction_prefetch_unit #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fifo_count     (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns the byte at whatever address is currently requested.
  assign imem_rdata = mem[imem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Fetch order from the instruction set rules.
  function automatic logic [7:0] next_pc(input logic [7:0] pc, input logic [7:0] ins);
`ifdef PREFETCH_JUMP_PREDECODE_EN
    if (ins[7:6] == 2'b10) return {pc[7:6], ins[5:0]};
`endif
    return pc + 8'd1;
  endfunction

  // Reference model: runs after inputs settle, before the next rising edge.
  always begin
    @(negedge clk);
    #2;
    if (reset) begin
      exp_q.delete();
      drop = 1'b0;
      mpc  = 8'h00;
    end else begin
      if (imem_req && imem_ack && !drop && !redirect_valid) begin
        check("fetch_addr", 32'(imem_addr), 32'(mpc));
        exp_q.push_back('{pc: mpc, ins: mem[mpc]});
        mpc = next_pc(mpc, mem[mpc]);
      end
      if (redirect_valid) begin
        exp_q.delete();
        mpc  = redirect_pc;
        // An in-flight request not answered this cycle must have its answer thrown away.
        drop = imem_req && !imem_ack;
      end else if (imem_req && imem_ack && drop) begin
        drop = 1'b0;
      end
    end
  end

  // Monitor: compares DUT outputs with the model's predictions.
  always begin
    @(negedge clk);
    if (!reset) begin
      check("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() == DEPTH) check("req_when_full", 32'(imem_req), 32'd0);
      if (out_valid && out_ready && exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("out_pc", 32'(out_pc), 32'(mon_e.pc));
        check("out_instr", 32'(out_instr), 32'(mon_e.ins));
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_count(input logic [2:0] target, input string name);
    int n = 0;
    while (fifo_count != target && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(fifo_count), 32'(target));
  endtask

  int         n_req;
  logic [7:0] exp_addr;
  logic [7:0] seq_ins [4];

  initial begin
    reset          = 1'b0;
    imem_ack       = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    // Reset values, checked before any clock edge.
    #1 reset = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_out_instr", 32'(out_instr), 32'd0);
    check("rst_out_pc", 32'(out_pc), 32'd0);

    // Streaming: immediate acks, decode always ready.
    seq_ins[0] = 8'h11; seq_ins[1] = 8'h22; seq_ins[2] = 8'h33; seq_ins[3] = 8'h44;
    for (int i = 0; i < 4; i++) mem[i] = seq_ins[i];
    out_ready = 1'b1;
    imem_ack  = 1'b1;
    do_reset();
    @(posedge clk);
    @(negedge clk);
    check("first_edge_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    check("second_edge_req", 32'(imem_req), 32'd1);
    check("second_edge_addr", 32'(imem_addr), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("seq_valid", 32'(out_valid), 32'd1);
      check("seq_pc", 32'(out_pc), 32'(k));
      check("seq_instr", 32'(out_instr), 32'(seq_ins[k]));
    end

    // Fill to capacity, then a single pop must trigger exactly one refill.
    out_ready = 1'b0;
    imem_ack  = 1'b1;
    do_reset();
    wait_count(3'd4, "full_count");
    repeat (3) @(negedge clk);
    check("full_req_low", 32'(imem_req), 32'd0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    n_req = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (imem_req && imem_ack) n_req++;
    end
    check("refill_requests", 32'(n_req), 32'd1);
    check("refill_count", 32'(fifo_count), 32'd4);

    // Redirect while a request waits for its ack.
    out_ready = 1'b0;
    imem_ack  = 1'b0;
    do_reset();
    n_req = 0;
    while (!imem_req && n_req < 20) begin
      @(negedge clk);
      n_req++;
    end
    check("drop_req_seen", 32'(imem_req), 32'd1);
    @(posedge clk);
    #1 begin redirect_valid = 1'b1; redirect_pc = 8'h40; end
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    @(negedge clk);
    check("drop_req_held", 32'(imem_req), 32'd1);
    check("drop_addr_held", 32'(imem_addr), 32'd0);
    @(posedge clk);
    #1 imem_ack = 1'b1;
    @(posedge clk);
    #1 imem_ack = 1'b0;
    @(negedge clk);
    check("drop_no_push", 32'(fifo_count), 32'd0);
    check("drop_req_released", 32'(imem_req), 32'd0);
    @(negedge clk);
    check("drop_next_req", 32'(imem_req), 32'd1);
    check("drop_next_addr", 32'(imem_addr), 32'h40);
    @(posedge clk);
    #1 imem_ack = 1'b1;
    repeat (3) @(posedge clk);

    // PC wrap from 8'hFF.
    out_ready      = 1'b0;
    imem_ack       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 8'hFF;
    do_reset();
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    wait_count(3'd1, "wrap_push");
    check("wrap_out_pc", 32'(out_pc), 32'hFF);
    check("wrap_next_addr", 32'(imem_addr), 32'h00);

    // Jump predecode at pc 5.
    mem[5]         = 8'b10_000100;
    redirect_valid = 1'b1;
    redirect_pc    = 8'h05;
    do_reset();
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    wait_count(3'd1, "pred_push");
    check("pred_out_pc", 32'(out_pc), 32'h05);
`ifdef PREFETCH_JUMP_PREDECODE_EN
    exp_addr = 8'h04;
`else
    exp_addr = 8'h06;
`endif
    check("pred_next_addr", 32'(imem_addr), 32'(exp_addr));

    // Reset in the middle of a request with three entries queued.
    do_reset();
    wait_count(3'd3, "mid_fill");
    imem_ack = 1'b0;
    check("mid_req_pending", 32'(imem_req), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    check("mid_rst_req", 32'(imem_req), 32'd0);
    imem_ack = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("late_ack_ignored", 32'(fifo_count), 32'd0);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      out_ready      = ($urandom_range(0, 99) < 65);
      imem_ack       = ($urandom_range(0, 99) < 60);
      redirect_valid = ($urandom_range(0, 99) < 4);
      redirect_pc    = 8'($urandom);
    end
    @(posedge clk);
    #1 begin redirect_valid = 1'b0; out_ready = 1'b1; imem_ack = 1'b1; end
    repeat (20) @(posedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
